// File: rtl/regwb_queue.sv
// regwb_queue: buffered writeback stage for the TinyRISC pipeline.
// Accepts one MA->WB bundle per cycle, selects the write address and data,
// queues up to DEPTH pending register writes and drains them in program
// order to a shared register-file write port under rf_gnt.
// Optional feature macro: WB_BYPASS_EN (youngest-match bypass search over
// pending entries). Without it byp_hit/byp_data are tied to 0.
module regwb_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          alu_result,
    input  logic [DATA_W-1:0]          ld_result,
    input  logic [DATA_W-1:0]          prpc,
    input  logic                       is_ld,
    input  logic                       is_call,
    input  logic                       is_wb,
    input  logic [ADDR_W-1:0]          ra,
    input  logic [ADDR_W-1:0]          rd,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    input  logic                       rf_gnt,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    input  logic [ADDR_W-1:0]          byp_addr,
    output logic                       byp_hit,
    output logic [DATA_W-1:0]          byp_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    entry_t             in_entry;
    entry_t             head;
    logic               push;
    logic               pop;

    // Status derives from the registered count only, so a full queue never
    // accepts in the same cycle it pops.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign rf_we     = (count_q != '0);
    assign occupancy = count_q;

    assign head      = mem_q[rd_ptr_q];
    assign rf_waddr  = rf_we ? head.addr : '0;
    assign rf_wdata  = rf_we ? head.data : '0;

    // Writeback select: a call writes the return PC to ra and wins over a load.
    always_comb begin
        in_entry.addr = is_call ? ra : rd;
        if (is_call) begin
            in_entry.data = prpc;
        end else if (is_ld) begin
            in_entry.data = ld_result;
        end else begin
            in_entry.data = alu_result;
        end
    end

    // Next-state for storage, pointers and count; non-writing bundles are
    // consumed without touching the queue.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        push = in_valid & in_ready & is_wb;
        pop  = rf_we & rf_gnt;

        if (push) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards all pending entries and overrides any
    // grant seen in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge value regardless of statement order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; an entry is only
        // observed when the count marks it valid, and all outputs are gated.
        mem_q <= mem_d;
    end

`ifdef WB_BYPASS_EN
    // Search valid entries oldest to youngest so the youngest match wins;
    // an entry being popped this cycle is still visible.
    always_comb begin : byp_search
        logic [PTR_W-1:0] idx;
        idx      = '0;
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (mem_q[idx].addr == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = mem_q[idx].data;
            end
        end
    end
`else
    assign byp_hit  = 1'b0;
    assign byp_data = '0;

    logic unused_byp_addr;
    assign unused_byp_addr = ^byp_addr;
`endif

endmodule

// File: tb/tb_regwb_queue.sv
// Self-checking bench for regwb_queue: table-driven vectors, hand-written
// corner sequences and a random phase, all checked against a scoreboard of
// expected register writes.
module tb_regwb_queue;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_result, ld_result, prpc;
    logic              is_ld, is_call, is_wb;
    logic [ADDR_W-1:0] ra, rd;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_gnt;
    logic [CNT_W-1:0]  occupancy;
    logic [ADDR_W-1:0] byp_addr;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

    always #5 clk = ~clk;

    regwb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .ld_result(ld_result), .prpc(prpc),
        .is_ld(is_ld), .is_call(is_call), .is_wb(is_wb), .ra(ra), .rd(rd),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_gnt(rf_gnt), .occupancy(occupancy), .byp_addr(byp_addr),
        .byp_hit(byp_hit), .byp_data(byp_data)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        logic              valid, wb, ld, call;
        logic [DATA_W-1:0] alu, ldr, pc;
        logic [ADDR_W-1:0] ra_i, rd_i;
        logic              gnt;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    wr_t  sb[$];
    wr_t  cur_exp;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic wr_t sel(input logic ld, call, input logic [DATA_W-1:0] alu, ldr, pc,
                                input logic [ADDR_W-1:0] ra_i, rd_i);
        wr_t w;
        w.addr = call ? ra_i : rd_i;
        w.data = call ? pc : (ld ? ldr : alu);
        return w;
    endfunction

    task automatic drive(input logic v, wb, ld, call, input logic [DATA_W-1:0] alu, ldr, pc,
                         input logic [ADDR_W-1:0] ra_i, rd_i, input logic gnt);
        in_valid = v; is_wb = wb; is_ld = ld; is_call = call;
        alu_result = alu; ld_result = ldr; prpc = pc; ra = ra_i; rd = rd_i;
        rf_gnt = gnt;
        cur_exp = sel(ld, call, alu, ldr, pc, ra_i, rd_i);
    endtask

    task automatic idle(input logic gnt);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, gnt);
    endtask

    // One clock: compare all outputs against the scoreboard mid-cycle, then
    // advance the scoreboard with whatever handshakes happen at the edge.
    task automatic cycle();
        logic full;
        logic exp_hit;
        logic [DATA_W-1:0] exp_byp;
        @(negedge clk);
        full = (sb.size() == DEPTH);
        check("occupancy", occupancy, sb.size());
        check("in_ready", in_ready, !full);
        check("rf_we", rf_we, sb.size() != 0);
        if (sb.size() != 0) begin
            check("rf_waddr", rf_waddr, sb[0].addr);
            check("rf_wdata", rf_wdata, sb[0].data);
        end else begin
            check("rf_waddr_idle", rf_waddr, 0);
            check("rf_wdata_idle", rf_wdata, 0);
        end
        exp_hit = 1'b0;
        exp_byp = '0;
`ifdef WB_BYPASS_EN
        foreach (sb[i]) begin
            if (sb[i].addr == byp_addr) begin
                exp_hit = 1'b1;
                exp_byp = sb[i].data;
            end
        end
`endif
        check("byp_hit", byp_hit, exp_hit);
        check("byp_data", byp_data, exp_byp);
        if (rst) begin
            sb.delete();
        end else begin
            if (sb.size() != 0 && rf_gnt) void'(sb.pop_front());
            if (in_valid && !full && is_wb) sb.push_back(cur_exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Writes with grant held: each entry appears one cycle after accept.
        vecs[0] = '{1, 1, 0, 0, 32'h11, 32'h0, 32'h0, 4'd0, 4'd3, 1, 4'd3, 32'h11};
        vecs[1] = '{1, 1, 1, 0, 32'h22, 32'h33, 32'h0, 4'd0, 4'd4, 1, 4'd4, 32'h33};
        vecs[2] = '{1, 1, 1, 1, 32'h0, 32'h55, 32'h40, 4'd15, 4'd2, 1, 4'd15, 32'h40};
        vecs[3] = '{1, 0, 0, 0, 32'h66, 32'h0, 32'h0, 4'd0, 4'd6, 1, 4'd0, 32'h0};
        vecs[4] = '{1, 1, 0, 1, 32'h1, 32'h2, 32'h80, 4'd14, 4'd1, 1, 4'd14, 32'h80};
        vecs[5] = '{1, 0, 1, 1, 32'h7, 32'h77, 32'h70, 4'd9, 4'd8, 1, 4'd0, 32'h0};
        vecs[6] = '{1, 1, 0, 0, 32'hDEAD_BEEF, 32'h1, 32'h2, 4'd5, 4'd0, 1, 4'd0, 32'hDEAD_BEEF};
        vecs[7] = '{0, 1, 0, 0, 32'h99, 32'h0, 32'h0, 4'd0, 4'd7, 1, 4'd0, 32'h0};

        rst = 1'b1;
        byp_addr = '0;
        idle(1'b0);
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        check("rst_occupancy", occupancy, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_byp_hit", byp_hit, 0);

        // Table-driven select / address / is_wb filtering.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].valid, vecs[i].wb, vecs[i].ld, vecs[i].call, vecs[i].alu,
                  vecs[i].ldr, vecs[i].pc, vecs[i].ra_i, vecs[i].rd_i, vecs[i].gnt);
            byp_addr = vecs[i].rd_i;
            cur_exp.addr = vecs[i].exp_addr;
            cur_exp.data = vecs[i].exp_data;
            cycle();
        end
        repeat (3) cycle();

        // Fill with grant low, hold a fifth bundle, then drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 32'h100 + i, 0, 0, 0, 4'(8 + i), 0);
            cycle();
        end
        check("full_occupancy", occupancy, 4);
        check("full_in_ready", in_ready, 0);
        drive(1, 1, 0, 0, 32'h200, 0, 0, 0, 4'd12, 0);
        repeat (2) cycle();
        check("held_occupancy", occupancy, 4);
        rf_gnt = 1'b1;
        cycle();
        check("ready_after_pop", in_ready, 1);
        check("pop_occupancy", occupancy, 3);
        cycle();
        check("push_pop_occupancy", occupancy, 3);
        idle(1'b1);
        repeat (5) cycle();
        check("drained", occupancy, 0);

        // Bypass: two writes to r5, youngest wins; then misses.
        drive(1, 1, 0, 0, 32'h1, 0, 0, 0, 4'd5, 0);
        cycle();
        drive(1, 1, 0, 0, 32'h2, 0, 0, 0, 4'd5, 0);
        cycle();
        drive(1, 1, 0, 0, 32'h3, 0, 0, 0, 4'd7, 0);
        cycle();
        idle(1'b0);
        byp_addr = 4'd5;
        #1;
`ifdef WB_BYPASS_EN
        check("byp_r5_hit", byp_hit, 1);
        check("byp_r5_data", byp_data, 32'h2);
`else
        check("byp_r5_hit", byp_hit, 0);
        check("byp_r5_data", byp_data, 0);
`endif
        cycle();
        byp_addr = 4'd7;
        cycle();
        byp_addr = 4'd9;
        cycle();

        // Reset with three pending entries and grant asserted.
        rst = 1'b1;
        rf_gnt = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst2_occupancy", occupancy, 0);
        check("rst2_rf_we", rf_we, 0);
        check("rst2_in_ready", in_ready, 1);
        check("rst2_byp_hit", byp_hit, 0);
        repeat (4) cycle();

        // Random traffic with a narrow register range to exercise bypass.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  $urandom, $urandom, $urandom,
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) == 0));
            byp_addr = 4'($urandom_range(0, 3));
            cycle();
        end
        idle(1'b1);
        repeat (6) cycle();
        check("final_empty", occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
